// File: rtl/midi_uart_receiver.sv
// MIDI serial front end: 2-FF synchronizer, 8N1 UART receiver and a
// channel-message assembler with running status.
//
// Ports:
//   clock          system clock
//   reset          synchronous, active-high reset
//   midi_rx        asynchronous serial MIDI line (idle high)
//   midi_busy      high while a message is being assembled; falls in the
//                  cycle a new midi_result becomes valid
//   midi_result    {status nibble, channel, data1, data2}
//   byte_strobe    one-cycle pulse per correctly framed byte
//   framing_error  one-cycle pulse when a stop bit samples low
module midi_uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 3200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        midi_rx,
    output logic        midi_busy,
    output logic [23:0] midi_result,
    output logic        byte_strobe,
    output logic        framing_error
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    // UART receiver states
    localparam logic [2:0] U_IDLE      = 3'd0;
    localparam logic [2:0] U_START     = 3'd1;
    localparam logic [2:0] U_DATA      = 3'd2;
    localparam logic [2:0] U_STOP      = 3'd3;
    localparam logic [2:0] U_WAIT_HIGH = 3'd4;

    // Assembler states
    localparam logic [1:0] A_WAIT_STATUS = 2'd0;
    localparam logic [1:0] A_WAIT_D1     = 2'd1;
    localparam logic [1:0] A_WAIT_D2     = 2'd2;

    logic          rx_meta;
    logic          rx_s;
    logic [2:0]    uart_state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_shift;

    logic [1:0]    asm_state;
    logic [7:0]    running_status;
    logic          rs_valid;
    logic [7:0]    data1;

    // Note-on with velocity 0 is reported as note-off.
    function automatic logic [23:0] pack_msg(input logic [7:0] st,
                                             input logic [7:0] d1,
                                             input logic [7:0] d2);
        logic [3:0] nib;
        nib = (st[7:4] == 4'h9 && d2 == 8'h00) ? 4'h8 : st[7:4];
        return {nib, st[3:0], d1, d2};
    endfunction

    // Synchronizer, idles high
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= midi_rx;
            rx_s    <= rx_meta;
        end
    end

    // UART receiver
    always_ff @(posedge clock) begin
        if (reset) begin
            uart_state    <= U_IDLE;
            clk_cnt       <= '0;
            bit_idx       <= '0;
            rx_shift      <= '0;
            byte_strobe   <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            byte_strobe   <= 1'b0;
            framing_error <= 1'b0;
            case (uart_state)
                U_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (!rx_s) uart_state <= U_START;
                end
                U_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt    <= '0;
                        uart_state <= rx_s ? U_IDLE : U_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                U_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt  <= '0;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        if (bit_idx == 3'd7) uart_state <= U_STOP;
                        bit_idx <= bit_idx + 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                U_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            byte_strobe <= 1'b1;
                            uart_state  <= U_IDLE;
                        end else begin
                            framing_error <= 1'b1;
                            uart_state    <= U_WAIT_HIGH;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                U_WAIT_HIGH: begin
                    if (rx_s) uart_state <= U_IDLE;
                end
                default: uart_state <= U_IDLE;
            endcase
        end
    end

    // Message assembler. rx_shift is stable while byte_strobe is high,
    // so completion lands one cycle after the final strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            asm_state      <= A_WAIT_STATUS;
            running_status <= '0;
            rs_valid       <= 1'b0;
            data1          <= '0;
            midi_busy      <= 1'b0;
            midi_result    <= '0;
        end else if (byte_strobe) begin
            if (rx_shift[7:3] == 5'b11111) begin
                // realtime: no effect at all
            end else if (rx_shift[7:4] == 4'hF) begin
                // system common / SysEx: drop running status, keep busy as is
                rs_valid  <= 1'b0;
                asm_state <= A_WAIT_STATUS;
            end else if (rx_shift[7]) begin
                running_status <= rx_shift;
                rs_valid       <= 1'b1;
                midi_busy      <= 1'b1;
                asm_state      <= A_WAIT_D1;
            end else begin
                case (asm_state)
                    A_WAIT_STATUS, A_WAIT_D1: begin
                        if (asm_state == A_WAIT_D1 || rs_valid) begin
                            data1 <= rx_shift;
                            if (running_status[7:5] == 3'b110) begin
                                midi_result <= pack_msg(running_status, rx_shift, 8'h00);
                                midi_busy   <= 1'b0;
                                asm_state   <= A_WAIT_STATUS;
                            end else begin
                                midi_busy <= 1'b1;
                                asm_state <= A_WAIT_D2;
                            end
                        end
                    end
                    A_WAIT_D2: begin
                        midi_result <= pack_msg(running_status, data1, rx_shift);
                        midi_busy   <= 1'b0;
                        asm_state   <= A_WAIT_STATUS;
                    end
                    default: asm_state <= A_WAIT_STATUS;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_midi_uart_receiver.sv
// Directed self-checking bench for midi_uart_receiver at 16 clocks per bit.
module tb_midi_uart_receiver;

    localparam int unsigned CPB = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        midi_rx;
    logic        midi_busy;
    logic [23:0] midi_result;
    logic        byte_strobe;
    logic        framing_error;

    int errors = 0;
    int checks = 0;

    int unsigned cyc = 0;
    int unsigned strobe_tot = 0;
    int unsigned ferr_tot = 0;
    int unsigned fall_tot = 0;
    int unsigned last_strobe_cyc = 0;
    int unsigned last_fall_cyc = 0;
    logic        prev_busy = 1'b0;
    int unsigned start_cyc = 0;

    midi_uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clock(clock),
        .reset(reset),
        .midi_rx(midi_rx),
        .midi_busy(midi_busy),
        .midi_result(midi_result),
        .byte_strobe(byte_strobe),
        .framing_error(framing_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Event monitor; a busy drop caused by reset is not a message edge.
    always @(negedge clock) begin
        if (byte_strobe === 1'b1) begin
            strobe_tot      <= strobe_tot + 1;
            last_strobe_cyc <= cyc;
        end
        if (framing_error === 1'b1) ferr_tot <= ferr_tot + 1;
        if (reset !== 1'b1 && prev_busy === 1'b1 && midi_busy === 1'b0) begin
            fall_tot      <= fall_tot + 1;
            last_fall_cyc <= cyc;
        end
        prev_busy <= (reset === 1'b1) ? 1'b0 : midi_busy;
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        @(posedge clock); #1;
        midi_rx   = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(posedge clock);
        for (int i = 0; i < 8; i++) begin
            #1 midi_rx = b[i];
            repeat (CPB) @(posedge clock);
        end
        #1 midi_rx = stop_val;
        repeat (CPB) @(posedge clock);
        #1 midi_rx = 1'b1;
        repeat (4) @(posedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1);
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        midi_rx = 1'b1;
        repeat (4) @(posedge clock);
        @(negedge clock);
        checks++; if (midi_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", midi_busy); end
        checks++; if (midi_result !== 24'h0) begin errors++; $display("FAIL reset_result: got %h expected 000000", midi_result); end
        checks++; if (byte_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", byte_strobe); end
        checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", framing_error); end
        @(posedge clock); #1 reset = 1'b0;
        repeat (10) @(posedge clock);
    endtask

    task automatic test_note_on;
        int unsigned s0, f0, e0, lat;
        s0 = strobe_tot; f0 = fall_tot; e0 = ferr_tot;
        send_byte(8'h90);
        lat = last_strobe_cyc - start_cyc;
        checks++; if (lat < 153 || lat > 156) begin errors++; $display("FAIL strobe_latency: got %0d expected 153..156", lat); end
        checks++; if (midi_busy !== 1'b1) begin errors++; $display("FAIL busy_after_status: got %b expected 1", midi_busy); end
        send_byte(8'h3C);
        send_byte(8'h64);
        checks++; if (fall_tot - f0 != 1) begin errors++; $display("FAIL note_on_falls: got %0d expected 1", fall_tot - f0); end
        checks++; if (midi_result !== 24'h903C64) begin errors++; $display("FAIL note_on_result: got %h expected 903c64", midi_result); end
        checks++; if (strobe_tot - s0 != 3) begin errors++; $display("FAIL note_on_strobes: got %0d expected 3", strobe_tot - s0); end
        checks++; if (ferr_tot != e0) begin errors++; $display("FAIL note_on_ferr: got %0d expected 0", ferr_tot - e0); end
        checks++; if (midi_busy !== 1'b0) begin errors++; $display("FAIL note_on_busy: got %b expected 0", midi_busy); end
        checks++; if (last_fall_cyc - last_strobe_cyc != 1) begin errors++; $display("FAIL completion_delay: got %0d expected 1", last_fall_cyc - last_strobe_cyc); end
    endtask

    task automatic test_running_status;
        int unsigned f0;
        f0 = fall_tot;
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        send_byte(8'h3E); send_byte(8'h00);
        checks++; if (fall_tot - f0 != 2) begin errors++; $display("FAIL running_falls: got %0d expected 2", fall_tot - f0); end
        checks++; if (midi_result !== 24'h803E00) begin errors++; $display("FAIL running_result: got %h expected 803e00", midi_result); end
    endtask

    task automatic test_realtime;
        int unsigned f0, s0;
        f0 = fall_tot; s0 = strobe_tot;
        send_byte(8'h91); send_byte(8'hF8); send_byte(8'h40);
        send_byte(8'hFE); send_byte(8'h7F);
        checks++; if (fall_tot - f0 != 1) begin errors++; $display("FAIL realtime_falls: got %0d expected 1", fall_tot - f0); end
        checks++; if (midi_result !== 24'h91407F) begin errors++; $display("FAIL realtime_result: got %h expected 91407f", midi_result); end
        checks++; if (strobe_tot - s0 != 5) begin errors++; $display("FAIL realtime_strobes: got %0d expected 5", strobe_tot - s0); end
    endtask

    task automatic test_sysex_abandon;
        int unsigned f0;
        f0 = fall_tot;
        send_byte(8'hC2); send_byte(8'h05);
        checks++; if (midi_result !== 24'hC20500) begin errors++; $display("FAIL prog_change_result: got %h expected c20500", midi_result); end
        checks++; if (fall_tot - f0 != 1) begin errors++; $display("FAIL prog_change_falls: got %0d expected 1", fall_tot - f0); end
        f0 = fall_tot;
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF0);
        send_byte(8'h3D); send_byte(8'h10);
        checks++; if (midi_result !== 24'hC20500) begin errors++; $display("FAIL sysex_result: got %h expected c20500", midi_result); end
        checks++; if (midi_busy !== 1'b1) begin errors++; $display("FAIL sysex_busy: got %b expected 1", midi_busy); end
        checks++; if (fall_tot != f0) begin errors++; $display("FAIL sysex_falls: got %0d expected 0", fall_tot - f0); end
    endtask

    task automatic test_framing;
        int unsigned s0, e0, f0;
        s0 = strobe_tot; e0 = ferr_tot;
        send_frame(8'h90, 1'b0);
        checks++; if (ferr_tot - e0 != 1) begin errors++; $display("FAIL framing_pulses: got %0d expected 1", ferr_tot - e0); end
        checks++; if (strobe_tot != s0) begin errors++; $display("FAIL framing_strobes: got %0d expected 0", strobe_tot - s0); end
        f0 = fall_tot;
        send_byte(8'h80); send_byte(8'h3C); send_byte(8'h40);
        checks++; if (midi_result !== 24'h803C40) begin errors++; $display("FAIL after_framing_result: got %h expected 803c40", midi_result); end
        checks++; if (fall_tot - f0 != 1) begin errors++; $display("FAIL after_framing_falls: got %0d expected 1", fall_tot - f0); end
    endtask

    task automatic test_glitch_and_reset;
        int unsigned s0, f0;
        s0 = strobe_tot;
        @(posedge clock); #1 midi_rx = 1'b0;
        repeat (4) @(posedge clock);
        #1 midi_rx = 1'b1;
        repeat (200) @(posedge clock);
        checks++; if (strobe_tot != s0) begin errors++; $display("FAIL glitch_strobes: got %0d expected 0", strobe_tot - s0); end

        f0 = fall_tot;
        send_byte(8'h90);
        checks++; if (midi_busy !== 1'b1) begin errors++; $display("FAIL prereset_busy: got %b expected 1", midi_busy); end
        // partial data1 byte 3C: start bit plus three data bits, then reset
        @(posedge clock); #1 midi_rx = 1'b0;
        repeat (CPB) @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            #1 midi_rx = (i == 2);
            repeat (CPB) @(posedge clock);
        end
        #1 begin midi_rx = 1'b1; reset = 1'b1; end
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (midi_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", midi_busy); end
        checks++; if (midi_result !== 24'h0) begin errors++; $display("FAIL midreset_result: got %h expected 000000", midi_result); end
        checks++; if (byte_strobe !== 1'b0 || framing_error !== 1'b0) begin errors++; $display("FAIL midreset_pulses: got %b%b expected 00", byte_strobe, framing_error); end
        @(posedge clock); #1 reset = 1'b0;
        repeat (40) @(posedge clock);
        checks++; if (fall_tot != f0) begin errors++; $display("FAIL midreset_falls: got %0d expected 0", fall_tot - f0); end
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        checks++; if (midi_result !== 24'h903C64) begin errors++; $display("FAIL postreset_result: got %h expected 903c64", midi_result); end
        checks++; if (fall_tot - f0 != 1) begin errors++; $display("FAIL postreset_falls: got %0d expected 1", fall_tot - f0); end
    endtask

    initial begin
        test_reset;
        test_note_on;
        test_running_status;
        test_realtime;
        test_sysex_abandon;
        test_framing;
        test_glitch_and_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
